// File: rtl/rot_mem_pkg.sv
// Shared types and helpers for the rotation memory responder.
// Holds the FSM state enum, the address field widths and the function that packs the
// {frame, row, column} fields of a rotation buffer word into a flat word address.
package rot_mem_pkg;

  localparam int unsigned FRAME_W    = 1;
  localparam int unsigned ROW_W      = 10;
  localparam int unsigned COL_W      = 10;
  localparam int unsigned RAW_ADDR_W = FRAME_W + ROW_W + COL_W;
  // Burst counters: wide enough to hold the largest burst length (16).
  localparam int unsigned CNT_W      = 5;

  typedef enum logic [1:0] {
    StIdle,
    StWrBurst,
    StRdIssue,
    StRdDrain
  } state_e;

  // Column advances by the burst index and wraps inside the row; no carry into row.
  function automatic logic [RAW_ADDR_W-1:0] compose_addr(
    input logic [FRAME_W-1:0] frame,
    input logic [ROW_W-1:0]   row,
    input logic [COL_W-1:0]   col,
    input logic [CNT_W-1:0]   index
  );
    logic [COL_W-1:0] col_i;
    col_i = col + COL_W'(index);
    return {frame, row, col_i};
  endfunction

endpackage

// File: rtl/rot_burst_counter.sv
// Per-channel burst bookkeeping: counts commands accepted by the RAM (issued) and
// read words returned (returned).
// Ports:
//   clk_sys, reset_n : clock, async active-low reset
//   clear            : restart both counts at burst start
//   issue_inc        : one command accepted this cycle
//   return_inc       : one read word returned this cycle
//   issued           : commands accepted so far in this burst (the burst index)
//   issue_last       : the command currently presented is the final one of the burst
//   return_done      : all words of the burst have been returned
module rot_burst_counter
  import rot_mem_pkg::*;
#(
  parameter int unsigned BURST = 16
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             issue_inc,
  input  logic             return_inc,
  output logic [CNT_W-1:0] issued,
  output logic             issue_last,
  output logic             return_done
);

  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] returned_q, returned_d;

  always_comb begin
    issued_d   = issued_q;
    returned_d = returned_q;
    if (clear) begin
      issued_d   = '0;
      returned_d = '0;
    end else begin
      if (issue_inc)  issued_d   = issued_q + CNT_W'(1);
      if (return_inc) returned_d = returned_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      issued_q   <= '0;
      returned_q <= '0;
    end else begin
      issued_q   <= issued_d;
      returned_q <= returned_d;
    end
  end

  assign issued      = issued_q;
  assign issue_last  = (issued_q == CNT_W'(BURST - 1));
  assign return_done = (returned_q == CNT_W'(BURST));

endmodule

// File: rtl/rotation_mem_responder.sv
// Memory-side responder for the scandoubler rotation interface. Serves WR_BURST-word
// write bursts (vidin_*) and RD_BURST-word read bursts (vidout_*) on one pipelined
// word-wide RAM port. Read wins a same-cycle tie; bursts never preempt or interleave.
// Ports:
//   clk_sys, reset_n         : clock, async active-low reset
//   vidin_req/frame/row/col  : write burst request and start address fields
//   vidin_d, vidin_ack       : write word, consumed when vidin_ack is high
//   vidout_req/frame/row/col : read burst request and start address fields
//   vidout_d, vidout_ack     : registered read data and its valid strobe
//   mem_req/we/addr/d        : RAM command, accepted when mem_ack is high
//   mem_q, mem_qvalid        : in-order read returns
module rotation_mem_responder
  import rot_mem_pkg::*;
#(
  parameter int unsigned ADDR_W    = 22,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned WR_BURST  = 16,
  parameter int unsigned RD_BURST  = 8
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              vidin_req,
  input  logic              vidin_frame,
  input  logic [ROW_W-1:0]  vidin_row,
  input  logic [COL_W-1:0]  vidin_col,
  input  logic [15:0]       vidin_d,
  output logic              vidin_ack,
  input  logic              vidout_req,
  input  logic              vidout_frame,
  input  logic [ROW_W-1:0]  vidout_row,
  input  logic [COL_W-1:0]  vidout_col,
  output logic [15:0]       vidout_d,
  output logic              vidout_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_d,
  input  logic              mem_ack,
  input  logic [15:0]       mem_q,
  input  logic              mem_qvalid
);

  state_e state_q, state_d;

  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic               mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic               mask_wr_q, mask_wr_d;
  logic               mask_rd_q, mask_rd_d;
  logic [15:0]        vidout_d_q;
  logic               vidout_ack_q;

  logic             wr_clear, rd_clear;
  logic [CNT_W-1:0] wr_issued, rd_issued;
  logic             wr_issue_last, rd_issue_last;
  logic             wr_return_done, rd_return_done;
  logic             unused_wr_return_done;

  logic wr_eligible, rd_eligible;
  logic wr_accept, rd_accept, rd_active, rd_return;

  function automatic logic [ADDR_W-1:0] make_addr(
    input logic [FRAME_W-1:0] frame,
    input logic [ROW_W-1:0]   row,
    input logic [COL_W-1:0]   col,
    input logic [CNT_W-1:0]   index
  );
    return ADDR_W'(BASE_ADDR) + ADDR_W'(compose_addr(frame, row, col, index));
  endfunction

  // A channel whose burst just finished stays masked until its req is seen low.
  assign wr_eligible = vidin_req & ~mask_wr_q;
  assign rd_eligible = vidout_req & ~mask_rd_q;

  assign wr_accept = mem_ack & (state_q == StWrBurst);
  assign rd_accept = mem_ack & (state_q == StRdIssue);
  assign rd_active = (state_q == StRdIssue) | (state_q == StRdDrain);
  // Returns outside a read burst (e.g. stale ones after reset) are dropped.
  assign rd_return = mem_qvalid & rd_active;

  rot_burst_counter #(
    .BURST(WR_BURST)
  ) u_wr_cnt (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .clear      (wr_clear),
    .issue_inc  (wr_accept),
    .return_inc (1'b0),
    .issued     (wr_issued),
    .issue_last (wr_issue_last),
    .return_done(wr_return_done)
  );

  rot_burst_counter #(
    .BURST(RD_BURST)
  ) u_rd_cnt (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .clear      (rd_clear),
    .issue_inc  (rd_accept),
    .return_inc (rd_return),
    .issued     (rd_issued),
    .issue_last (rd_issue_last),
    .return_done(rd_return_done)
  );

  // Writes complete on accept; the write return count is never used.
  assign unused_wr_return_done = wr_return_done;

  // State register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (rd_eligible)      state_d = StRdIssue;
        else if (wr_eligible) state_d = StWrBurst;
      end
      StWrBurst: if (wr_accept && wr_issue_last) state_d = StIdle;
      StRdIssue: if (rd_accept && rd_issue_last) state_d = StRdDrain;
      StRdDrain: if (rd_return_done)             state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Burst datapath next-state: address capture, command stream, masks.
  always_comb begin
    frame_d    = frame_q;
    row_d      = row_q;
    col_d      = col_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    wr_clear   = 1'b0;
    rd_clear   = 1'b0;
    mask_wr_d  = vidin_req ? mask_wr_q : 1'b0;
    mask_rd_d  = vidout_req ? mask_rd_q : 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rd_eligible) begin
          frame_d    = vidout_frame;
          row_d      = vidout_row;
          col_d      = vidout_col;
          mem_req_d  = 1'b1;
          mem_addr_d = make_addr(vidout_frame, vidout_row, vidout_col, '0);
          rd_clear   = 1'b1;
        end else if (wr_eligible) begin
          frame_d    = vidin_frame;
          row_d      = vidin_row;
          col_d      = vidin_col;
          mem_req_d  = 1'b1;
          mem_addr_d = make_addr(vidin_frame, vidin_row, vidin_col, '0);
          wr_clear   = 1'b1;
        end
      end
      StWrBurst: begin
        if (wr_accept) begin
          mem_addr_d = make_addr(frame_q, row_q, col_q, wr_issued + CNT_W'(1));
          if (wr_issue_last) begin
            mem_req_d = 1'b0;
            mask_wr_d = 1'b1;
          end
        end
      end
      StRdIssue: begin
        if (rd_accept) begin
          mem_addr_d = make_addr(frame_q, row_q, col_q, rd_issued + CNT_W'(1));
          if (rd_issue_last) mem_req_d = 1'b0;
        end
      end
      StRdDrain: if (rd_return_done) mask_rd_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      frame_q      <= '0;
      row_q        <= '0;
      col_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      mask_wr_q    <= 1'b0;
      mask_rd_q    <= 1'b0;
      vidout_d_q   <= '0;
      vidout_ack_q <= 1'b0;
    end else begin
      frame_q      <= frame_d;
      row_q        <= row_d;
      col_q        <= col_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      mask_wr_q    <= mask_wr_d;
      mask_rd_q    <= mask_rd_d;
      vidout_d_q   <= mem_q;
      vidout_ack_q <= rd_return;
    end
  end

  // Outputs.
  always_comb begin
    mem_req    = mem_req_q;
    mem_addr   = mem_addr_q;
    mem_we     = (state_q == StWrBurst);
    mem_d      = vidin_d;
    vidin_ack  = wr_accept;
    vidout_d   = vidout_d_q;
    vidout_ack = vidout_ack_q;
  end

endmodule
